spi_flash_rd_seq: RTL and testbench
===================================

// Module: spi_flash_rd_seq
// PURPOSE
//  Wishbone master that sequences the SPI_wb register block to perform SPI-flash READ transactions.
//  Accepts a (24-bit address, length) request, then issues CS-hold, opcode, address and dummy-TX bytes.
//  Streams received data bytes out with valid/ready and releases CS when done.
//  Sits between the XIP/boot logic and one SPI_wb instance, and is the only master on that instance's bus.
// PARAMETERS
//  NCS          4      chip-select count of the attached SPI_wb
//  CS_SEL       1      one-hot ACS value written to CSCTRL[24+NCS-1:24]
//  SCKDIV       1      value written to SCKDIV at init
//  CPOL         0      SCTRL.pol written at init
//  CPHA         0      SCTRL.pha written at init
//  READ_CMD     8'h03  opcode byte sent first
//  START_POLLS  4      max SCTRL polls waiting for busy=1 after a TDATA write
// PORTS
//  wb_clk_i     in   1   clock
//  wb_rstn_i    in   1   asynchronous active-low reset
//  req_valid_i  in   1   request valid
//  req_ready_o  out  1   request accepted when valid&ready
//  req_addr_i   in   24  flash byte address
//  req_len_i    in   8   byte count minus 1 (0 means 1 byte, 255 means 256 bytes)
//  rd_valid_o   out  1   received data byte valid
//  rd_ready_i   in   1   consumer ready
//  rd_data_o    out  8   received data byte
//  done_o       out  1   one-cycle pulse after CS release
//  m_adr_o      out  3   SPI_wb word address [4:2]
//  m_dat_o      out  32  write data
//  m_dat_i      in   32  read data
//  m_we_o       out  1   write enable
//  m_sel_o      out  4   byte selects
//  m_stb_o      out  1   strobe
//  m_ack_i      in   1   acknowledge
// BEHAVIOUR
//  Reset state:
//   - All outputs 0; FSM=INIT_DIV.
//   - req_ready_o stays 0 until init completes.
//  Bus access rules:
//   - One access outstanding at a time.
//   - adr/dat/we/sel are held stable while stb=1.
//   - stb drops in the same cycle ack is sampled high; next access starts no earlier than the following cycle.
//  INIT_DIV:  write adr 0 = SCKDIV, sel 4'hF.
//  INIT_CTRL: write adr 1 = {27'd0, loopen=0, end=0, CPHA, CPOL, spien=1}, sel 4'h1. Then go to IDLE.
//  IDLE:
//   - req_ready_o=1.
//   - On accept, latch addr and len; byte counter bc=0.
//   - Go to CS_ON.
//  CS_ON: write adr 4 = {CS_SEL<<24 | 2'b11}, sel 4'h9 (CS held asserted).
//  TX: write adr 2, sel 4'h1. dat[7:0] is selected by bc:
//   - bc=0: READ_CMD
//   - bc=1: addr[23:16]
//   - bc=2: addr[15:8]
//   - bc=3: addr[7:0]
//   - bc>=4: 8'h00
//  POLL: read adr 1, busy = m_dat_i[31].
//   - Wait for busy=1, then for busy=0.
//   - If busy=1 is never observed within START_POLLS reads, treat the byte as complete.
//  Header bytes (bc<4) go POLL -> TX with bc+1.
//  RX: read adr 3; latch m_dat_i[7:0] into rd_data_o.
//  PUSH:
//   - rd_valid_o=1 until rd_ready_i=1. rd_data_o is held stable.
//   - No bus activity in this state.
//   - If bc-4 == len, go to CS_OFF; else go to TX with bc+1.
//  CS_OFF: write adr 4 = {CS_SEL<<24 | 2'b00}, sel 4'h9.
//  DONE: done_o=1 for one cycle, then go to IDLE.
//  Counter widths:
//   - bc is 9 bits, so len=255 gives 260 TX bytes with no wrap.
//   - Poll counter saturates at START_POLLS.
//  Boundaries:
//   - req_valid_i is ignored outside IDLE.
//   - Back-to-back requests: IDLE accepts in the cycle following done_o.
//  Reset mid-operation:
//   - Asynchronously abort to INIT_DIV with stb=0.
//   - The attached SPI_wb must share the reset, so CS returns high via SPI_wb's own reset.
// STRUCTURE
//  Shared package spi_pkg:
//   - Register offsets SCKDIV=0, SCTRL=1, TDATA=2, RDATA=3, CSCTRL=4, DCTRL=5.
//   - SCTRL_BUSY_BIT=31.
//   - CSMODE_AUTO=2'b00, CSMODE_HOLD=2'b11.
//   - FSM state enum.
//  Sub-module spi_wb_mstr_port: single-access Wishbone master (start/we/adr/dat/sel in; busy/rdata/done out).
//  The FSM drives only spi_wb_mstr_port.
// TESTING (bench: SPI_wb plus SPI flash model, SCKDIV=1)
//  1. Release reset -> exactly two bus writes: adr0=0x1, then adr1=0x1 sel=1; req_ready_o rises after the second ack.
//  2. req addr=0x123456 len=0, flash[0x123456]=0xA5:
//     - MOSI bytes 03 12 34 56 00.
//     - One rd beat 0xA5, CS low throughout.
//     - done_o after CSCTRL=0.
//  3. addr=0x000010 len=3, rd_ready_i toggles 1/0 each cycle:
//     - Four beats equal flash[0x10..0x13], in order.
//     - No TDATA write while rd_valid_o=1 and unaccepted.
//  4. Stub slave that never reports busy=1 -> exactly START_POLLS SCTRL reads per byte; transaction still completes.
//  5. Deassert wb_rstn_i during data byte 2 of len=7:
//     - m_stb_o=0 immediately, cs_o all-ones.
//     - After release, the init writes repeat and a fresh request completes correctly.
//  6. req_valid_i held high across two requests (len=255, then len=0):
//     - 256 beats, then 1 beat.
//     - Second accept occurs exactly one cycle after the first done_o.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Package : spi_pkg
// Register map, CS modes and read-sequencer state encoding for SPI_wb.
// Rev 1.0
// ============================================================================
package spi_pkg;

  localparam logic [2:0] REG_SCKDIV = 3'd0;
  localparam logic [2:0] REG_SCTRL  = 3'd1;
  localparam logic [2:0] REG_TDATA  = 3'd2;
  localparam logic [2:0] REG_RDATA  = 3'd3;
  localparam logic [2:0] REG_CSCTRL = 3'd4;
  localparam logic [2:0] REG_DCTRL  = 3'd5;

  localparam int SCTRL_BUSY_BIT = 31;
  localparam int HDR_BYTES      = 4;

  localparam logic [1:0] CSMODE_AUTO = 2'b00;
  localparam logic [1:0] CSMODE_HOLD = 2'b11;

  typedef enum logic [3:0] {
    ST_INIT_DIV  = 4'd0,
    ST_INIT_CTRL = 4'd1,
    ST_IDLE      = 4'd2,
    ST_CS_ON     = 4'd3,
    ST_TX        = 4'd4,
    ST_POLL      = 4'd5,
    ST_RX        = 4'd6,
    ST_PUSH      = 4'd7,
    ST_CS_OFF    = 4'd8,
    ST_DONE      = 4'd9
  } rd_state_e;

  // Byte shifted out for position bc: opcode, 3 address bytes, then dummies.
  function automatic logic [7:0] tx_byte(input logic [8:0]  bc,
                                         input logic [23:0] addr,
                                         input logic [7:0]  cmd);
    case (bc)
      9'd0:    return cmd;
      9'd1:    return addr[23:16];
      9'd2:    return addr[15:8];
      9'd3:    return addr[7:0];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] csctrl_word(input logic [31:0] acs,
                                              input logic [1:0]  mode);
    return (acs << 24) | {30'd0, mode};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_wb_mstr_port.sv
`default_nettype none
// ============================================================================
// Module : spi_wb_mstr_port
// Single-outstanding Wishbone master; registered done/rdata one cycle after ack.
// Rev 1.0
// ============================================================================
module spi_wb_mstr_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [2:0]  adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic        busy_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic [2:0]  m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic        m_stb_o,
  input  logic        m_ack_i
);

  logic        stb_q,   stb_d;
  logic        we_q,    we_d;
  logic [2:0]  adr_q,   adr_d;
  logic [31:0] dat_q,   dat_d;
  logic [3:0]  sel_q,   sel_d;
  logic        done_q,  done_d;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    if (stb_q) begin
      if (m_ack_i) begin
        stb_d   = 1'b0;
        done_d  = 1'b1;
        rdata_d = m_dat_i;
      end
    end else if (start_i && !done_q) begin
      // Address phase fields are frozen here and held until ack.
      stb_d = 1'b1;
      we_d  = we_i;
      adr_d = adr_i;
      dat_d = dat_i;
      sel_d = sel_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 3'd0;
      dat_q   <= 32'd0;
      sel_q   <= 4'd0;
      done_q  <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy_o  = stb_q | done_q;
  assign done_o  = done_q;
  assign rdata_o = rdata_q;
  assign m_stb_o = stb_q;
  assign m_we_o  = we_q;
  assign m_adr_o = adr_q;
  assign m_dat_o = dat_q;
  assign m_sel_o = sel_q;

endmodule
`default_nettype wire

// File: rtl/spi_flash_rd_seq.sv
`default_nettype none
// ============================================================================
// Module : spi_flash_rd_seq
// Drives SPI_wb over Wishbone to perform SPI-flash READ (opcode, addr, dummies).
// Rev 1.0
// ============================================================================
module spi_flash_rd_seq
  import spi_pkg::*;
#(
  parameter int             NCS         = 4,
  parameter logic [NCS-1:0] CS_SEL      = NCS'(1),
  parameter logic [31:0]    SCKDIV      = 32'd1,
  parameter logic           CPOL        = 1'b0,
  parameter logic           CPHA        = 1'b0,
  parameter logic [7:0]     READ_CMD    = 8'h03,
  parameter int             START_POLLS = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [23:0] req_addr_i,
  input  logic [7:0]  req_len_i,
  output logic        rd_valid_o,
  input  logic        rd_ready_i,
  output logic [7:0]  rd_data_o,
  output logic        done_o,
  output logic [2:0]  m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic        m_stb_o,
  input  logic        m_ack_i
);

  localparam int PW = $clog2(START_POLLS + 1);

  rd_state_e   state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [8:0]  bc_q, bc_d;
  logic [PW-1:0] poll_q, poll_d;
  logic        seen_q, seen_d;
  logic [7:0]  rd_data_q, rd_data_d;

  logic        acc_go, acc_we;
  logic [2:0]  acc_adr;
  logic [31:0] acc_dat;
  logic [3:0]  acc_sel;
  logic        port_busy, port_done;
  logic [31:0] port_rdata;
  logic        busy_bit, byte_end;
  logic        unused_rdata;

  assign busy_bit     = port_rdata[SCTRL_BUSY_BIT];
  assign unused_rdata = ^port_rdata[30:8];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    bc_d      = bc_q;
    poll_d    = poll_q;
    seen_d    = seen_q;
    rd_data_d = rd_data_q;
    acc_go    = 1'b0;
    acc_we    = 1'b1;
    acc_adr   = REG_SCKDIV;
    acc_dat   = 32'd0;
    acc_sel   = 4'hF;
    byte_end  = 1'b0;

    unique case (state_q)
      ST_INIT_DIV: begin
        acc_go  = 1'b1;
        acc_dat = SCKDIV;
        if (port_done) state_d = ST_INIT_CTRL;
      end
      ST_INIT_CTRL: begin
        acc_go  = 1'b1;
        acc_adr = REG_SCTRL;
        acc_dat = {27'd0, 1'b0, 1'b0, CPHA, CPOL, 1'b1};
        acc_sel = 4'h1;
        if (port_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          len_d   = req_len_i;
          bc_d    = 9'd0;
          state_d = ST_CS_ON;
        end
      end
      ST_CS_ON: begin
        acc_go  = 1'b1;
        acc_adr = REG_CSCTRL;
        acc_dat = csctrl_word(32'(CS_SEL), CSMODE_HOLD);
        acc_sel = 4'h9;
        if (port_done) state_d = ST_TX;
      end
      ST_TX: begin
        acc_go  = 1'b1;
        acc_adr = REG_TDATA;
        acc_dat = {24'd0, tx_byte(bc_q, addr_q, READ_CMD)};
        acc_sel = 4'h1;
        poll_d  = '0;
        seen_d  = 1'b0;
        if (port_done) state_d = ST_POLL;
      end
      ST_POLL: begin
        acc_go  = 1'b1;
        acc_we  = 1'b0;
        acc_adr = REG_SCTRL;
        if (port_done) begin
          if (seen_q) begin
            byte_end = !busy_bit;
          end else if (busy_bit) begin
            seen_d = 1'b1;
          end else begin
            // A transfer too short to ever catch busy=1 still completes.
            poll_d   = (poll_q == PW'(START_POLLS)) ? poll_q : poll_q + PW'(1);
            byte_end = (poll_q + PW'(1) >= PW'(START_POLLS));
          end
          if (byte_end) begin
            if (bc_q < 9'(HDR_BYTES)) begin
              bc_d    = bc_q + 9'd1;
              state_d = ST_TX;
            end else begin
              state_d = ST_RX;
            end
          end
        end
      end
      ST_RX: begin
        acc_go  = 1'b1;
        acc_we  = 1'b0;
        acc_adr = REG_RDATA;
        if (port_done) begin
          rd_data_d = port_rdata[7:0];
          state_d   = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (rd_ready_i) begin
          if (bc_q - 9'(HDR_BYTES) == {1'b0, len_q}) begin
            state_d = ST_CS_OFF;
          end else begin
            bc_d    = bc_q + 9'd1;
            state_d = ST_TX;
          end
        end
      end
      ST_CS_OFF: begin
        acc_go  = 1'b1;
        acc_adr = REG_CSCTRL;
        acc_dat = csctrl_word(32'(CS_SEL), CSMODE_AUTO);
        acc_sel = 4'h9;
        if (port_done) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_INIT_DIV;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q   <= ST_INIT_DIV;
      addr_q    <= 24'd0;
      len_q     <= 8'd0;
      bc_q      <= 9'd0;
      poll_q    <= '0;
      seen_q    <= 1'b0;
      rd_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      bc_q      <= bc_d;
      poll_q    <= poll_d;
      seen_q    <= seen_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rd_valid_o  = (state_q == ST_PUSH);
  assign done_o      = (state_q == ST_DONE);
  assign rd_data_o   = rd_data_q;

  spi_wb_mstr_port u_port (
    .clk     (wb_clk_i),
    .rst_n   (wb_rstn_i),
    .start_i (acc_go && !port_busy),
    .we_i    (acc_we),
    .adr_i   (acc_adr),
    .dat_i   (acc_dat),
    .sel_i   (acc_sel),
    .busy_o  (port_busy),
    .rdata_o (port_rdata),
    .done_o  (port_done),
    .m_adr_o (m_adr_o),
    .m_dat_o (m_dat_o),
    .m_dat_i (m_dat_i),
    .m_we_o  (m_we_o),
    .m_sel_o (m_sel_o),
    .m_stb_o (m_stb_o),
    .m_ack_i (m_ack_i)
  );

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_rd_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_flash_rd_seq
// Bench: behavioural SPI_wb + flash slave, reference model of READ transactions.
// Rev 1.0
// ============================================================================
module tb_spi_flash_rd_seq;

  localparam int START_POLLS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = 24'd0;
  logic [7:0]  req_len = 8'd0;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  rd_data;
  logic        done;
  logic [2:0]  m_adr;
  logic [31:0] m_dat_o;
  logic [31:0] m_dat_i;
  logic        m_we;
  logic [3:0]  m_sel;
  logic        m_stb;
  logic        m_ack;

  always #5 clk = ~clk;

  spi_flash_rd_seq #(
    .NCS(4), .CS_SEL(4'b0001), .SCKDIV(32'd1), .CPOL(1'b0), .CPHA(1'b0),
    .READ_CMD(8'h03), .START_POLLS(START_POLLS)
  ) dut (
    .wb_clk_i(clk), .wb_rstn_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_len_i(req_len),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .done_o(done),
    .m_adr_o(m_adr), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_we_o(m_we),
    .m_sel_o(m_sel), .m_stb_o(m_stb), .m_ack_i(m_ack)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  endtask

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (a == 24'h123456) return 8'hA5;
    return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h3C;
  endfunction

  // ---------------- behavioural SPI_wb + flash slave ----------------------
  bit          stub_mode = 1'b0;
  int          wait_cnt, busy_cnt, tx_idx, cur_polls;
  logic [31:0] csctrl_r;
  logic [23:0] faddr;
  logic [7:0]  rx_r;
  int          cs_viol, push_viol;
  logic [7:0]  mosi_q[$];
  logic [7:0]  beats_q[$];
  int          polls_q[$];
  logic [2:0]  log_adr[$];
  logic [31:0] log_dat[$];
  logic        log_we[$];
  logic [3:0]  log_sel[$];

  function automatic logic cs_held();
    return (csctrl_r[1:0] == 2'b11) && (csctrl_r[27:24] == 4'b0001);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ack     <= 1'b0;
      m_dat_i   <= 32'd0;
      wait_cnt  <= 0;
      busy_cnt  <= 0;
      tx_idx    <= 0;
      cur_polls <= 0;
      csctrl_r  <= 32'd0;
      faddr     <= 24'd0;
      rx_r      <= 8'd0;
    end else begin
      m_ack <= 1'b0;
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      if (m_stb && !m_ack) begin
        if (wait_cnt > 0) begin
          wait_cnt <= wait_cnt - 1;
        end else begin
          wait_cnt <= $urandom_range(0, 2);
          m_ack    <= 1'b1;
          log_adr.push_back(m_adr);
          log_dat.push_back(m_dat_o);
          log_we.push_back(m_we);
          log_sel.push_back(m_sel);
          if (m_we) begin
            if (m_adr == 3'd2) begin
              if (!cs_held()) cs_viol <= cs_viol + 1;
              if (rd_valid) push_viol <= push_viol + 1;
              mosi_q.push_back(m_dat_o[7:0]);
              if (tx_idx != 0) polls_q.push_back(cur_polls);
              cur_polls <= 0;
              if (tx_idx >= 1 && tx_idx <= 3) faddr <= {faddr[15:0], m_dat_o[7:0]};
              rx_r     <= (tx_idx >= 4) ? flash_byte(faddr + 24'(tx_idx - 4)) : 8'hFF;
              tx_idx   <= tx_idx + 1;
              busy_cnt <= stub_mode ? 0 : int'($urandom_range(1, 10));
            end else if (m_adr == 3'd4) begin
              if (tx_idx != 0) polls_q.push_back(cur_polls);
              csctrl_r <= m_dat_o;
              tx_idx   <= 0;
            end
          end else begin
            if (m_adr == 3'd1) begin
              m_dat_i   <= {busy_cnt != 0, 31'd0};
              cur_polls <= cur_polls + 1;
            end else if (m_adr == 3'd3) begin
              m_dat_i <= {24'd0, rx_r};
            end else begin
              m_dat_i <= 32'd0;
            end
          end
        end
      end
    end
  end

  // ---------------- monitors ----------------------------------------------
  int cyc = 0;
  int acc_cyc[$];
  int done_cyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_valid && rd_ready) beats_q.push_back(rd_data);
    if (done) done_cyc.push_back(cyc);
    if (req_valid && req_ready) acc_cyc.push_back(cyc);
  end

  int rd_mode = 0;
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rd_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ~rd_ready;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic wait_ready(input int budget);
    int n = 0;
    while (!req_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check_eq("ready_timeout", 32'(req_ready), 32'd1);
      finish_now();
    end
  endtask

  task automatic check_init();
    wait_ready(300);
    check_eq("init_acc_count", log_adr.size(), 2);
    if (log_adr.size() >= 2) begin
      check_eq("init0", {log_we[0], log_sel[0], log_adr[0]}, {1'b1, 4'hF, 3'd0});
      check_eq("init0_dat", log_dat[0], 32'h1);
      check_eq("init1", {log_we[1], log_sel[1], log_adr[1]}, {1'b1, 4'h1, 3'd1});
      check_eq("init1_dat", log_dat[1], 32'h1);
    end
  endtask

  task automatic check_beats(input logic [23:0] a, input int nb, input int base);
    for (int k = 0; k < nb; k++) begin
      if (base + k < beats_q.size())
        check_eq($sformatf("beat%0d", base + k), beats_q[base + k], flash_byte(a + 24'(k)));
    end
  endtask

  task automatic run_txn(input logic [23:0] a, input logic [7:0] l);
    int n = 0;
    int cv0, pv0;
    logic [7:0] exp_mosi[$];
    wait_ready(500);
    mosi_q.delete();
    beats_q.delete();
    polls_q.delete();
    cv0 = cs_viol;
    pv0 = push_viol;
    exp_mosi = '{8'h03, a[23:16], a[15:8], a[7:0]};
    for (int k = 0; k <= int'(l); k++) exp_mosi.push_back(8'h00);
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!done && n < 200 * (int'(l) + 6)) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      check_eq("done_timeout", 32'(done), 32'd1);
      finish_now();
    end
    check_eq("csctrl_release", csctrl_r, 32'h0100_0000);
    check_eq("mosi_count", mosi_q.size(), exp_mosi.size());
    for (int k = 0; k < exp_mosi.size() && k < mosi_q.size(); k++)
      check_eq($sformatf("mosi%0d", k), mosi_q[k], exp_mosi[k]);
    check_eq("beat_count", beats_q.size(), int'(l) + 1);
    check_beats(a, int'(l) + 1, 0);
    check_eq("cs_low_throughout", cs_viol - cv0, 0);
    check_eq("no_tx_while_push", push_viol - pv0, 0);
    @(negedge clk);
  endtask

  // ---------------- main sequence -----------------------------------------
  initial begin
    cs_viol   = 0;
    push_viol = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", {req_ready, rd_valid, done, m_stb, m_we, m_sel, m_adr},
             {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0});
    check_eq("rst_dat", m_dat_o, 32'd0);
    rst_n = 1'b1;
    check_init();

    rd_mode = 0;
    run_txn(24'h123456, 8'd0);
    check_eq("a5_beat", (beats_q.size() > 0) ? beats_q[0] : 8'h00, 8'hA5);

    rd_mode = 1;
    run_txn(24'h000010, 8'd3);

    rd_mode   = 0;
    stub_mode = 1'b1;
    run_txn(24'h0ABCDE, 8'd1);
    check_eq("stub_poll_bytes", polls_q.size(), 6);
    foreach (polls_q[k]) check_eq($sformatf("stub_polls%0d", k), polls_q[k], START_POLLS);
    stub_mode = 1'b0;

    for (int t = 0; t < 4; t++) begin
      rd_mode = $urandom_range(0, 2);
      run_txn(24'($urandom), 8'($urandom_range(0, 12)));
    end

    // Reset while the third data byte is in flight.
    rd_mode = 0;
    wait_ready(500);
    beats_q.delete();
    req_addr  = 24'h00F000;
    req_len   = 8'd7;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    begin
      int n = 0;
      while (beats_q.size() < 2 && n < 2000) begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("mid_beats_reached", beats_q.size(), 2);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_stb", 32'(m_stb), 32'd0);
    check_eq("abort_cs_n", cs_held() ? 4'b1110 : 4'b1111, 4'b1111);
    check_eq("abort_flags", {req_ready, rd_valid, done}, 3'b000);
    repeat (2) @(negedge clk);
    log_adr.delete();
    log_dat.delete();
    log_we.delete();
    log_sel.delete();
    rst_n = 1'b1;
    check_init();
    run_txn(24'h00F000, 8'd7);

    // req_valid held across two requests.
    rd_mode = 2;
    wait_ready(500);
    acc_cyc.delete();
    done_cyc.delete();
    beats_q.delete();
    req_addr  = 24'h3FFF80;
    req_len   = 8'd255;
    req_valid = 1'b1;
    @(negedge clk);
    req_addr = 24'h777777;
    req_len  = 8'd0;
    begin
      int n = 0;
      while (done_cyc.size() < 2 && n < 60000) begin
        @(negedge clk);
        if (acc_cyc.size() >= 2) req_valid = 1'b0;
        n++;
      end
    end
    req_valid = 1'b0;
    check_eq("b2b_accepts", acc_cyc.size(), 2);
    check_eq("b2b_dones", done_cyc.size(), 2);
    if (acc_cyc.size() >= 2 && done_cyc.size() >= 1)
      check_eq("b2b_accept_gap", acc_cyc[1] - done_cyc[0], 1);
    check_eq("b2b_beat_count", beats_q.size(), 257);
    check_beats(24'h3FFF80, 256, 0);
    check_beats(24'h777777, 1, 256);

    repeat (5) @(negedge clk);
    finish_now();
  end

endmodule
`default_nettype wire
